// File: rtl/single_trunc_arbiter.sv
// Round-robin front end sharing one truncate-toward-zero unit between NUM_REQ requesters.
// Define SINGLE_TRUNC_ARB_CHECK_EN to build the sticky protocol checker that drives err.
module single_trunc_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int UNIT_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic                    unit_in_valid,
    output logic [31:0]             unit_a,
    input  logic                    unit_out_valid,
    input  logic [31:0]             unit_c,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [32*NUM_REQ-1:0]   rsp_data,
    output logic                    err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic valid;
        idx_t tag;
    } tag_t;

    logic [NUM_REQ-1:0]        busy_q, busy_d;
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [31:0]               rsp_data_q [NUM_REQ];
    logic [31:0]               rsp_data_d [NUM_REQ];
    idx_t                      rr_q, rr_d;
    tag_t [UNIT_LATENCY-1:0]   tag_q, tag_d;

    logic [NUM_REQ-1:0]        eligible;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        hs;
    idx_t                      grant_idx;
    tag_t                      tail;
    logic                      wr;
    int                        scan;

    assign eligible = req_valid & ~busy_q;
    assign tail     = tag_q[UNIT_LATENCY-1];
    assign hs       = rsp_valid_q & rsp_ready;
    assign wr       = unit_out_valid && tail.valid;

    // Scan downward so the last hit is the closest index at or above the pointer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        scan      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan = int'(rr_q) + k;
            if (scan >= NUM_REQ) scan = scan - NUM_REQ;
            if (eligible[scan]) begin
                grant       = '0;
                grant[scan] = 1'b1;
                grant_idx   = idx_t'(scan);
            end
        end
    end

    assign req_ready     = grant;
    assign unit_in_valid = |grant;
    assign unit_a        = unit_in_valid ? req_data[grant_idx*32 +: 32] : 32'h0;

`ifdef SINGLE_TRUNC_ARB_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rr_d        = rr_q;
        tag_d[0]    = {unit_in_valid, grant_idx};
        for (int s = 1; s < UNIT_LATENCY; s++) tag_d[s] = tag_q[s-1];

        if (unit_in_valid) begin
            busy_d = busy_q | grant;
            rr_d   = (grant_idx == idx_t'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end

        // A grant needs !busy and a handshake needs busy, so they never hit the same index.
        rsp_valid_d = rsp_valid_d & ~hs;
        busy_d      = busy_d & ~hs;

`ifdef SINGLE_TRUNC_ARB_CHECK_EN
        err_d = err_q;
        if (unit_out_valid != tail.valid) err_d = 1'b1;
        if (wr && rsp_valid_q[tail.tag]) begin
            err_d = 1'b1;
        end else if (wr) begin
            rsp_valid_d[tail.tag] = 1'b1;
            rsp_data_d[tail.tag]  = unit_c;
        end
`else
        if (wr) begin
            rsp_valid_d[tail.tag] = 1'b1;
            rsp_data_d[tail.tag]  = unit_c;
        end
`endif
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same cycle's values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rr_q        <= '0;
            tag_q       <= '0;
            // NOTE: the response registers are reset because their contents are visible on rsp_data.
            for (int i = 0; i < NUM_REQ; i++) rsp_data_q[i] <= '0;
        end else begin
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rr_q        <= rr_d;
            tag_q       <= tag_d;
            for (int i = 0; i < NUM_REQ; i++) rsp_data_q[i] <= rsp_data_d[i];
        end
    end

`ifdef SINGLE_TRUNC_ARB_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign rsp_valid = rsp_valid_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
        assign rsp_data[32*i +: 32] = rsp_data_q[i];
    end

endmodule
